// File: rtl/vend_pkg.sv
// Shared types and widths for the vending dispense controller.
// The state enum is 3 bits with IDLE encoded as zero.
package vend_pkg;

   localparam int CNT_W   = 8;
   localparam int ENTRY_W = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      P_REQ = 3'd1,
      P_REL = 3'd2,
      C_REQ = 3'd3,
      C_REL = 3'd4
   } vend_state_t;

   // Counters stop at zero instead of wrapping to 255
   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - CNT_W'(1);
   endfunction

endpackage

// File: rtl/vend_evt_fifo.sv
// Synchronous event FIFO. Pointers carry an extra MSB so that full and empty can be told apart.
// A push while full is accepted only when a pop happens in the same cycle.
module vend_evt_fifo
   import vend_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Queues sale events from the vending FSM and plays them out to the product and change
// actuators over 4-phase handshakes, tracking stock/coin counts and sticky fault flags.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STOCK_INIT = 8,
   parameter int COIN_INIT  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             p_in,
   input  logic             c_in,
   output logic             prod_req,
   input  logic             prod_ack,
   output logic             chg_req,
   input  logic             chg_ack,
   output logic             busy,
   output logic [CNT_W-1:0] stock_cnt,
   output logic [CNT_W-1:0] coin_cnt,
   output logic             overflow,
   output logic             stock_fault,
   output logic             coin_fault
);

   vend_state_t        state;
   logic [ENTRY_W-1:0] head;
   logic [ENTRY_W-1:0] entry;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   // The FSM takes a new event only from IDLE, so a freshly pushed entry is never popped that cycle
   assign pop  = (state == IDLE) && !fifo_empty;
   assign busy = (state != IDLE) || !fifo_empty;

   vend_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (p_in),
      .pop   (pop),
      .din   (c_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Request outputs are registered alongside the state so they change on the transition edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         entry       <= '0;
         prod_req    <= 1'b0;
         chg_req     <= 1'b0;
         stock_cnt   <= CNT_W'(STOCK_INIT);
         coin_cnt    <= CNT_W'(COIN_INIT);
         overflow    <= 1'b0;
         stock_fault <= 1'b0;
         coin_fault  <= 1'b0;
      end else begin
         if (p_in && fifo_full && !pop) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  entry <= head;
                  if (stock_cnt == '0) begin
                     stock_fault <= 1'b1;
                  end else begin
                     state    <= P_REQ;
                     prod_req <= 1'b1;
                  end
               end
            end
            P_REQ: begin
               if (prod_ack) begin
                  stock_cnt <= sat_dec(stock_cnt);
                  prod_req  <= 1'b0;
                  state     <= P_REL;
               end
            end
            P_REL: begin
               if (!prod_ack) begin
                  if (entry[0] && (coin_cnt != '0)) begin
                     state   <= C_REQ;
                     chg_req <= 1'b1;
                  end else begin
                     if (entry[0]) coin_fault <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            C_REQ: begin
               if (chg_ack) begin
                  coin_cnt <= sat_dec(coin_cnt);
                  chg_req  <= 1'b0;
                  state    <= C_REL;
               end
            end
            C_REL: begin
               if (!chg_ack) state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               prod_req <= 1'b0;
               chg_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: a default instance driven by a table plus corner sequences,
// and a low-inventory instance (one product, no coins) for the fault paths.
module tb_vend_dispense_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       m_p, m_c, m_prod_req, m_prod_ack, m_chg_req, m_chg_ack, m_busy;
   logic       m_ovf, m_sf, m_cf;
   logic [7:0] m_stock, m_coin;
   logic       l_p, l_c, l_prod_req, l_prod_ack, l_chg_req, l_chg_ack, l_busy;
   logic       l_ovf, l_sf, l_cf;
   logic [7:0] l_stock, l_coin;

   vend_dispense_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .p_in(m_p), .c_in(m_c),
      .prod_req(m_prod_req), .prod_ack(m_prod_ack), .chg_req(m_chg_req), .chg_ack(m_chg_ack),
      .busy(m_busy), .stock_cnt(m_stock), .coin_cnt(m_coin),
      .overflow(m_ovf), .stock_fault(m_sf), .coin_fault(m_cf)
   );

   vend_dispense_ctrl #(.DEPTH(4), .STOCK_INIT(1), .COIN_INIT(0)) u_dut_lo (
      .clk(clk), .rst_n(rst_n), .p_in(l_p), .c_in(l_c),
      .prod_req(l_prod_req), .prod_ack(l_prod_ack), .chg_req(l_chg_req), .chg_ack(l_chg_ack),
      .busy(l_busy), .stock_cnt(l_stock), .coin_cnt(l_coin),
      .overflow(l_ovf), .stock_fault(l_sf), .coin_fault(l_cf)
   );

   // The low-inventory instance gets zero-latency acknowledges
   assign l_prod_ack = l_prod_req;
   assign l_chg_ack  = l_chg_req;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   p_dly = 0, c_dly = 0, pcnt = 0, ccnt = 0;
   logic p_hold = 1'b0;
   int   exp_stock = 8, exp_coin = 8;
   int   exp_prod_q [$];
   int   exp_chg_q [$];
   logic prev_preq = 1'b0, prev_creq = 1'b0, prev_lpreq = 1'b0, prev_lcreq = 1'b0;
   int   l_prod_rises = 0, l_chg_rises = 0;

   typedef struct {
      logic       p;
      logic       c;
      int         dly;
      int         stock;
      int         coin;
      logic [2:0] flags;
   } vec_t;
   vec_t vecs [5];

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One cycle of drive on the default instance; dispensing events feed the scoreboard
   task automatic applyStimulus(input logic p, input logic c, input bit dropped);
      @(negedge clk);
      m_p = p;
      m_c = c;
      if (p && !dropped && exp_stock > 0) begin
         exp_prod_q.push_back(exp_stock);
         exp_stock--;
         if (c && exp_coin > 0) begin
            exp_chg_q.push_back(exp_coin);
            exp_coin--;
         end
      end
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      repeat (2) @(negedge clk);
      while ((m_busy || m_prod_ack || m_chg_ack || l_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_idle"}, int'(n < 200), 1);
   endtask

   // Actuator models for the default instance: ack after a delay, optionally held off
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prod_ack = 1'b0;
         pcnt = 0;
      end else if (!m_prod_req) begin
         m_prod_ack = 1'b0;
         pcnt = 0;
      end else if (!p_hold) begin
         if (pcnt >= p_dly) m_prod_ack = 1'b1;
         else pcnt++;
      end
   end

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_chg_ack = 1'b0;
         ccnt = 0;
      end else if (!m_chg_req) begin
         m_chg_ack = 1'b0;
         ccnt = 0;
      end else begin
         if (ccnt >= c_dly) m_chg_ack = 1'b1;
         else ccnt++;
      end
   end

   // Scoreboard: every request rising edge consumes one expected entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_prod_req && !prev_preq) begin
            checkOutput("prod_chg_excl", m_chg_req, 0);
            checkOutput("prod_expected", int'(exp_prod_q.size() > 0), 1);
            if (exp_prod_q.size() > 0) checkOutput("prod_stock", m_stock, exp_prod_q.pop_front());
         end
         if (m_chg_req && !prev_creq) begin
            checkOutput("chg_prod_excl", m_prod_req, 0);
            checkOutput("chg_expected", int'(exp_chg_q.size() > 0), 1);
            if (exp_chg_q.size() > 0) checkOutput("chg_coin", m_coin, exp_chg_q.pop_front());
         end
         if (l_prod_req && !prev_lpreq) l_prod_rises++;
         if (l_chg_req && !prev_lcreq) l_chg_rises++;
      end
      prev_preq  = m_prod_req;
      prev_creq  = m_chg_req;
      prev_lpreq = l_prod_req;
      prev_lcreq = l_chg_req;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 2, 7, 8, 3'b000};
      vecs[1] = '{1'b1, 1'b1, 0, 6, 7, 3'b000};
      vecs[2] = '{1'b0, 1'b1, 0, 6, 7, 3'b000};
      vecs[3] = '{1'b1, 1'b1, 3, 5, 6, 3'b000};
      vecs[4] = '{1'b1, 1'b0, 1, 4, 6, 3'b000};

      rst_n = 1'b0;
      m_p = 1'b0; m_c = 1'b0; l_p = 1'b0; l_c = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_stock", m_stock, 8);
      checkOutput("rst_coin", m_coin, 8);
      checkOutput("rst_busy", m_busy, 0);
      checkOutput("rst_reqs", {m_prod_req, m_chg_req}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         p_dly = vecs[i].dly;
         c_dly = vecs[i].dly;
         applyStimulus(vecs[i].p, vecs[i].c, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0);
         waitIdle($sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d_stock", i), m_stock, vecs[i].stock);
         checkOutput($sformatf("vec%0d_coin", i), m_coin, vecs[i].coin);
         checkOutput($sformatf("vec%0d_flags", i), {m_ovf, m_sf, m_cf}, vecs[i].flags);
      end

      // Low inventory: product with change but no coins, then a sale with no stock left
      @(negedge clk); l_p = 1'b1; l_c = 1'b1;
      @(negedge clk); l_p = 1'b0; l_c = 1'b0;
      waitIdle("lo_first");
      @(negedge clk); l_p = 1'b1;
      @(negedge clk); l_p = 1'b0;
      waitIdle("lo_second");
      checkOutput("lo_prod_rises", l_prod_rises, 1);
      checkOutput("lo_chg_rises", l_chg_rises, 0);
      checkOutput("lo_stock", l_stock, 0);
      checkOutput("lo_coin", l_coin, 0);
      checkOutput("lo_flags", {l_ovf, l_sf, l_cf}, 3'b011);

      // Request latency, then reset in the middle of a held handshake
      p_dly = 0; c_dly = 0; p_hold = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk); m_p = 1'b0;
      checkOutput("lat_edge1", m_prod_req, 0);
      @(negedge clk);
      checkOutput("lat_edge2", m_prod_req, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_prod_req", m_prod_req, 0);
      checkOutput("arst_busy", m_busy, 0);
      checkOutput("arst_stock", m_stock, 8);
      checkOutput("arst_coin", m_coin, 8);
      checkOutput("arst_lo_stock", l_stock, 1);
      checkOutput("arst_lo_flags", {l_ovf, l_sf, l_cf}, 0);
      exp_prod_q.delete();
      exp_chg_q.delete();
      exp_stock = 8;
      exp_coin  = 8;
      p_hold = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Six back-to-back events with the product ack held: one in the FSM, four queued, one dropped
      p_hold = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, i == 5);
      checkOutput("ovf_at_full", m_ovf, 0);
      @(negedge clk); m_p = 1'b0;
      checkOutput("ovf_after_drop", m_ovf, 1);
      p_hold = 1'b0;
      waitIdle("ovf");
      checkOutput("ovf_stock", m_stock, 3);
      checkOutput("ovf_coin", m_coin, 8);
      checkOutput("ovf_flags", {m_ovf, m_sf, m_cf}, 3'b100);
      checkOutput("prod_q_drained", exp_prod_q.size(), 0);
      checkOutput("chg_q_drained", exp_chg_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
